sum_serial_nb: RTL and testbench



---
 rtl/sum_serial_nb.sv | 126 ++++++++++++
 tb/tb_sum_serial_nb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_serial_nb.sv
// Bit-serial N-bit adder built around a single 1-bit full-adder cell.
// Operands stream through the cell LSB first, one bit per clock; the carry
// is held in a register between bits. The full-width sum, carry out and
// two's-complement overflow are published together with a one-cycle done.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; last result held on s/cout/ovf
// RUN   | one operand bit per cycle through the full-adder cell
// DONE  | single cycle, result just published; start may re-arm RUN

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module sum_serial_nb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    sa;
    logic [N-1:0]    sb;
    logic [N-1:0]    sr;
    logic            c;
    logic            cmsb;
    logic [CW-1:0]   cnt;
    logic            fa_s;
    logic            fa_co;
    logic            last_bit;

    fa_cell u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (c),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == CW'(N - 1));

    // cmsb and cout are loaded on the same edge, so their XOR is the
    // registered overflow and only moves when a new result is published.
    assign ovf = cmsb ^ cout;

    // Sequencer: operand capture, per-bit shifting and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            cmsb  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        c     <= ci;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sr  <= {fa_s, sr[N-1:1]};
                    c   <= fa_co;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        cmsb  <= c;
                        s     <= {fa_s, sr[N-1:1]};
                        cout  <= fa_co;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_serial_nb.sv
// Scoreboard bench for sum_serial_nb at N=4 and N=8. Stimulus pushes the
// expected result of every accepted request; negedge monitors pop and compare.

module tb_sum_serial_nb;

    typedef struct {
        int         t0;
        int         due;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_seen = 1'b1;
    int         cyc = 0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       ci4 = 1'b0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] s4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       ci8 = 1'b0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    exp_t q4[$];
    exp_t q8[$];
    exp_t last4;
    exp_t last8;
    int   nf4 = 0;
    int   nf8 = 0;
    int   acc4 = 0;
    int   acc8 = 0;
    int   checks = 0;
    int   errors = 0;

    sum_serial_nb #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    sum_serial_nb #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Reference: plain integer addition; overflow from the sign rule.
    function automatic exp_t model(input int n, input logic [7:0] a, input logic [7:0] b,
                                   input logic ci, input int t0);
        exp_t e;
        int   sum;
        sum    = int'(a) + int'(b) + int'(ci);
        e.t0   = t0;
        e.due  = t0 + n;
        e.s    = 8'(sum & ((1 << n) - 1));
        e.cout = sum[n];
        e.ovf  = (a[n-1] == b[n-1]) && (e.s[n-1] != a[n-1]);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Present the current inputs at the next edge and record what it accepts.
    task automatic drive();
        int t0;
        t0 = cyc + 1;
        if (rst) begin
            nf4 = 0;
            nf8 = 0;
        end else begin
            if (start4 && t0 >= nf4) begin
                q4.push_back(model(4, {4'b0, a4}, {4'b0, b4}, ci4, t0));
                nf4 = t0 + 5;
                acc4++;
            end
            if (start8 && t0 >= nf8) begin
                q8.push_back(model(8, a8, b8, ci8, t0));
                nf8 = t0 + 9;
                acc8++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        a4 = a; b4 = b; ci4 = ci; start4 = 1'b1;
        drive();
        start4 = 1'b0;
        for (int i = 0; i < 6; i++) drive();
    endtask

    // N=4 monitor
    always @(negedge clk) begin : mon4
        logic ed, eb;
        if (rst_seen) begin
            while (q4.size() > 0 && q4[0].t0 <= cyc) void'(q4.pop_front());
            last4 = '{default: '0};
            ed = 1'b0;
            eb = 1'b0;
        end else if (q4.size() > 0 && q4[0].due == cyc) begin
            last4 = q4.pop_front();
            ed = 1'b1;
            eb = 1'b0;
        end else begin
            ed = 1'b0;
            eb = (q4.size() > 0) && (cyc >= q4[0].t0) && (cyc < q4[0].due);
        end
        chk("n4_done", {8'b0, done4}, {8'b0, ed});
        chk("n4_busy", {8'b0, busy4}, {8'b0, eb});
        chk("n4_s",    {5'b0, s4},    {1'b0, last4.s});
        chk("n4_cout", {8'b0, cout4}, {8'b0, last4.cout});
        chk("n4_ovf",  {8'b0, ovf4},  {8'b0, last4.ovf});
    end

    // N=8 monitor
    always @(negedge clk) begin : mon8
        logic ed, eb;
        if (rst_seen) begin
            while (q8.size() > 0 && q8[0].t0 <= cyc) void'(q8.pop_front());
            last8 = '{default: '0};
            ed = 1'b0;
            eb = 1'b0;
        end else if (q8.size() > 0 && q8[0].due == cyc) begin
            last8 = q8.pop_front();
            ed = 1'b1;
            eb = 1'b0;
        end else begin
            ed = 1'b0;
            eb = (q8.size() > 0) && (cyc >= q8[0].t0) && (cyc < q8[0].due);
        end
        chk("n8_done", {8'b0, done8}, {8'b0, ed});
        chk("n8_busy", {8'b0, busy8}, {8'b0, eb});
        chk("n8_s",    {1'b0, s8},    {1'b0, last8.s});
        chk("n8_cout", {8'b0, cout8}, {8'b0, last8.cout});
        chk("n8_ovf",  {8'b0, ovf8},  {8'b0, last8.ovf});
    end

    initial begin
        int iter;
        rst = 1'b1;
        drive();
        drive();
        rst = 1'b0;
        drive();

        // directed sums, including overflow and carry corner cases
        op4(4'b0111, 4'b0001, 1'b0);
        op4(4'b1111, 4'b0001, 1'b0);
        op4(4'b1000, 4'b1000, 1'b0);
        op4(4'b0000, 4'b0000, 1'b1);
        op4(4'b1111, 4'b1111, 1'b1);

        // second start during RUN must be ignored
        a4 = 4'b0011; b4 = 4'b0011; ci4 = 1'b0; start4 = 1'b1;
        drive();
        start4 = 1'b0;
        drive();
        a4 = 4'b0101; b4 = 4'b0101; start4 = 1'b1;
        drive();
        start4 = 1'b0;
        for (int i = 0; i < 6; i++) drive();

        // start held high: back-to-back results
        start4 = 1'b1;
        for (int i = 0; i < 25; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
            drive();
        end
        start4 = 1'b0;
        for (int i = 0; i < 6; i++) drive();

        // reset mid-operation discards the partial result
        op4(4'b0011, 4'b0011, 1'b0);
        a4 = 4'b1010; b4 = 4'b0101; ci4 = 1'b0; start4 = 1'b1;
        drive();
        start4 = 1'b0;
        drive();
        rst = 1'b1;
        drive();
        rst = 1'b0;
        drive();
        op4(4'b1010, 4'b0101, 1'b1);

        // randomized traffic on both widths
        iter = 0;
        while ((acc4 < 1010 || acc8 < 1005) && iter < 40000) begin
            rst    = ($urandom_range(0, 799) == 0);
            start4 = ($urandom_range(0, 3) != 0);
            a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
            start8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            drive();
            iter++;
        end
        rst = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) drive();

        chk("n4_request_count", {8'b0, acc4 >= 1010}, 9'd1);
        chk("n8_request_count", {8'b0, acc8 >= 1005}, 9'd1);
        chk("n4_queue_drained", 9'(q4.size()), 9'd0);
        chk("n8_queue_drained", 9'(q8.size()), 9'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
